program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader_pkg.sv | 27 ++
 rtl/word_assembler.sv | 48 ++++
 rtl/program_loader.sv | 158 +++++++++++++++
 tb/tb_program_loader.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// Shared definitions for the serial program loader.
// Holds the loader state encoding, the framing constants (bytes per memory
// word, header length) and a small helper that says which states take bytes.
package program_loader_pkg;

  // Loader states, in the order a normal load walks through them.
  typedef enum logic [2:0] {
    LEN_HI = 3'd0,
    LEN_LO = 3'd1,
    DATA   = 3'd2,
    CSUM   = 3'd3,
    RUN    = 3'd4,
    ERROR  = 3'd5
  } loader_state_e;

  // Bytes that make up one 32-bit memory word.
  localparam int BYTES_PER_WORD = 4;

  // Number of length bytes that precede the payload.
  localparam int HEADER_LEN = 2;

  // True in the states where the host link may deliver a byte.
  function automatic logic accepts_bytes(input loader_state_e s);
    return (s == LEN_HI) || (s == LEN_LO) || (s == DATA) || (s == CSUM);
  endfunction

endpackage

// File: rtl/word_assembler.sv
// Byte-to-word assembler for the program loader.
// Collects BYTES_PER_WORD bytes big-endian (first byte lands in bits 31:24).
// Ports:
//   clock, reset   - clock and asynchronous active-high reset
//   clear          - synchronous restart of the byte counter
//   byte_valid     - byte_in is accepted this cycle
//   byte_in        - incoming payload byte
//   word_out       - assembled word; valid while word_valid is high
//   word_valid     - high on the cycle the last byte of a word is accepted
module word_assembler
  import program_loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_out,
  output logic        word_valid
);

  localparam int CNT_W = $clog2(BYTES_PER_WORD);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES_PER_WORD - 1);

  logic [CNT_W-1:0] byte_count;
  logic [23:0]      shift_reg;

  // Shift earlier bytes toward the top of the word; the counter wraps to 0
  // after the last byte so the next word starts cleanly with no idle cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      byte_count <= '0;
      shift_reg  <= '0;
    end else if (clear) begin
      byte_count <= '0;
      shift_reg  <= '0;
    end else if (byte_valid) begin
      byte_count <= byte_count + 1'b1;
      shift_reg  <= {shift_reg[15:0], byte_in};
    end
  end

  // The last byte is taken straight from the input so the complete word is
  // available in the same cycle it is accepted.
  assign word_valid = byte_valid && (byte_count == LAST_BYTE);
  assign word_out   = {shift_reg, byte_in};

endmodule

// File: rtl/program_loader.sv
// Serial program loader.
// Receives a framed program over a byte link (16-bit big-endian word count,
// payload words, XOR checksum byte), writes the words into memory starting at
// BASE_ADDR, then releases the CPU and hands it the memory bus.
// Ports:
//   clock, reset              - clock and asynchronous active-high reset
//   in_data/in_valid/in_ready - byte stream from the host (valid/ready)
//   load_req                  - restart a load from RUN or ERROR
//   cpu_address/cpu_data_out/cpu_we - CPU bus, forwarded to memory in RUN
//   mem_address/mem_data/mem_we     - memory write port
//   cpu_reset                 - held high until a load completes correctly
//   load_error                - high while parked after a checksum mismatch
module program_loader
  import program_loader_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        load_req,
  input  logic [15:0] cpu_address,
  input  logic [31:0] cpu_data_out,
  input  logic        cpu_we,
  output logic [15:0] mem_address,
  output logic [31:0] mem_data,
  output logic        mem_we,
  output logic        cpu_reset,
  output logic        load_error
);

  loader_state_e state, next_state;

  logic        accept;
  logic        restart;
  logic        last_word;
  logic [7:0]  len_hi;
  logic [7:0]  xor_acc;
  logic [15:0] word_count;
  logic [15:0] word_idx;
  logic        ld_we;
  logic [15:0] ld_addr;
  logic [31:0] ld_data;
  logic        cpu_reset_r;
  logic [31:0] asm_word;
  logic        asm_valid;

  assign in_ready   = accepts_bytes(state);
  assign accept     = in_valid && in_ready;
  assign restart    = load_req && ((state == RUN) || (state == ERROR));
  assign last_word  = (word_idx == (word_count - 16'd1));
  assign load_error = (state == ERROR);
  assign cpu_reset  = cpu_reset_r;

  word_assembler u_assembler (
    .clock      (clock),
    .reset      (reset),
    .clear      (restart),
    .byte_valid (accept && (state == DATA)),
    .byte_in    (in_data),
    .word_out   (asm_word),
    .word_valid (asm_valid)
  );

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= LEN_HI;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. A zero word count skips straight to the checksum byte;
  // load_req only matters once the loader has finished (RUN or ERROR).
  always_comb begin
    next_state = state;
    case (state)
      LEN_HI: begin
        if (accept) next_state = LEN_LO;
      end
      LEN_LO: begin
        if (accept) next_state = ({len_hi, in_data} == 16'd0) ? CSUM : DATA;
      end
      DATA: begin
        if (asm_valid && last_word) next_state = CSUM;
      end
      CSUM: begin
        if (accept) next_state = (in_data == xor_acc) ? RUN : ERROR;
      end
      RUN, ERROR: begin
        if (load_req) next_state = LEN_HI;
      end
      default: next_state = LEN_HI;
    endcase
  end

  // Loader datapath. The memory write is registered one cycle behind the
  // last byte of each word while the assembler already takes the next byte,
  // so the link never stalls. cpu_reset follows next_state so it drops on the
  // very edge that enters RUN and rises on the edge that leaves it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      len_hi      <= '0;
      xor_acc     <= '0;
      word_count  <= '0;
      word_idx    <= '0;
      ld_we       <= 1'b0;
      ld_addr     <= '0;
      ld_data     <= '0;
      cpu_reset_r <= 1'b1;
    end else begin
      ld_we       <= 1'b0;
      cpu_reset_r <= (next_state != RUN);

      if (restart) begin
        xor_acc  <= '0;
        word_idx <= '0;
      end

      if (accept && ((state == LEN_HI) || (state == LEN_LO) || (state == DATA))) begin
        xor_acc <= xor_acc ^ in_data;
      end

      if (accept && (state == LEN_HI)) begin
        len_hi <= in_data;
      end

      if (accept && (state == LEN_LO)) begin
        word_count <= {len_hi, in_data};
        word_idx   <= '0;
      end

      // The 16-bit sum wraps from FFFF back to 0000 on its own.
      if (asm_valid) begin
        ld_we    <= 1'b1;
        ld_addr  <= BASE_ADDR + word_idx;
        ld_data  <= asm_word;
        word_idx <= word_idx + 16'd1;
      end
    end
  end

  // Memory port: the CPU owns the bus in RUN, the loader everywhere else.
  always_comb begin
    mem_address = ld_addr;
    mem_data    = ld_data;
    mem_we      = ld_we;
    if (state == RUN) begin
      mem_address = cpu_address;
      mem_data    = cpu_data_out;
      mem_we      = cpu_we;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed testbench for program_loader.
// Two instances share the same stimulus: dut_a at BASE_ADDR 0000 and dut_b at
// BASE_ADDR FFFF (used for the address wrap case).
module tb_program_loader;
  import program_loader_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        load_req;
  logic [15:0] cpu_address;
  logic [31:0] cpu_data_out;
  logic        cpu_we;

  logic        a_in_ready, a_mem_we, a_cpu_reset, a_load_error;
  logic [15:0] a_mem_address;
  logic [31:0] a_mem_data;
  logic        b_in_ready, b_mem_we, b_cpu_reset, b_load_error;
  logic [15:0] b_mem_address;
  logic [31:0] b_mem_data;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  program_loader #(.BASE_ADDR(16'h0000)) dut_a (
    .clock        (clock),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (a_in_ready),
    .load_req     (load_req),
    .cpu_address  (cpu_address),
    .cpu_data_out (cpu_data_out),
    .cpu_we       (cpu_we),
    .mem_address  (a_mem_address),
    .mem_data     (a_mem_data),
    .mem_we       (a_mem_we),
    .cpu_reset    (a_cpu_reset),
    .load_error   (a_load_error)
  );

  program_loader #(.BASE_ADDR(16'hFFFF)) dut_b (
    .clock        (clock),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (b_in_ready),
    .load_req     (load_req),
    .cpu_address  (cpu_address),
    .cpu_data_out (cpu_data_out),
    .cpu_we       (cpu_we),
    .mem_address  (b_mem_address),
    .mem_data     (b_mem_data),
    .mem_we       (b_mem_we),
    .cpu_reset    (b_cpu_reset),
    .load_error   (b_load_error)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one byte on the link at a falling edge; it is taken on the next rising edge.
  task automatic applyStimulus(input logic [7:0] b);
    @(negedge clock);
    in_data  = b;
    in_valid = 1'b1;
  endtask

  task automatic idleCycle();
    @(negedge clock);
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic pulseLoadReq();
    @(negedge clock);
    in_valid = 1'b0;
    load_req = 1'b1;
    @(negedge clock);
    load_req = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    in_data      = 8'h00;
    in_valid     = 1'b0;
    load_req     = 1'b0;
    cpu_address  = 16'h0000;
    cpu_data_out = 32'h0;
    cpu_we       = 1'b0;

    // Reset state
    #1;
    checkOutput("rst_state",      32'(dut_a.state), 32'(LEN_HI));
    checkOutput("rst_cpu_reset",  32'(a_cpu_reset), 32'd1);
    checkOutput("rst_load_error", 32'(a_load_error), 32'd0);
    checkOutput("rst_mem_we",     32'(a_mem_we), 32'd0);
    checkOutput("rst_mem_addr",   32'(a_mem_address), 32'h0);
    checkOutput("rst_mem_data",   a_mem_data, 32'h0);
    checkOutput("rst_in_ready",   32'(a_in_ready), 32'd1);
    @(negedge clock);
    reset = 1'b0;

    // N=1, one word DEADBEEF, checksum 00^01^DE^AD^BE^EF = 23
    applyStimulus(8'h00);
    applyStimulus(8'h01);
    applyStimulus(8'hDE);
    applyStimulus(8'hAD);
    applyStimulus(8'hBE);
    checkOutput("n1_no_early_we", 32'(a_mem_we), 32'd0);
    applyStimulus(8'hEF);
    applyStimulus(8'h23);
    checkOutput("n1_we",          32'(a_mem_we), 32'd1);
    checkOutput("n1_addr",        32'(a_mem_address), 32'h0000);
    checkOutput("n1_data",        a_mem_data, 32'hDEADBEEF);
    checkOutput("n1_cpu_rst_hi",  32'(a_cpu_reset), 32'd1);
    idleCycle();
    checkOutput("n1_state_run",   32'(dut_a.state), 32'(RUN));
    checkOutput("n1_cpu_rst_lo",  32'(a_cpu_reset), 32'd0);
    checkOutput("n1_load_error",  32'(a_load_error), 32'd0);
    checkOutput("n1_in_ready",    32'(a_in_ready), 32'd0);
    checkOutput("n1_we_dropped",  32'(a_mem_we), 32'd0);

    // CPU owns the memory bus in RUN, same-cycle passthrough
    cpu_we       = 1'b1;
    cpu_address  = 16'h0010;
    cpu_data_out = 32'h12345678;
    #1;
    checkOutput("run_we",   32'(a_mem_we), 32'd1);
    checkOutput("run_addr", 32'(a_mem_address), 32'h0010);
    checkOutput("run_data", a_mem_data, 32'h12345678);
    cpu_we = 1'b0;
    #1;
    checkOutput("run_we_off", 32'(a_mem_we), 32'd0);

    // Reload request from RUN
    pulseLoadReq();
    checkOutput("reload_state",   32'(dut_a.state), 32'(LEN_HI));
    checkOutput("reload_cpu_rst", 32'(a_cpu_reset), 32'd1);
    checkOutput("reload_b_state", 32'(dut_b.state), 32'(LEN_HI));

    // N=2 on the FFFF-based instance, back-to-back bytes, checksum 8A
    applyStimulus(8'h00);
    applyStimulus(8'h02);
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    load_req = 1'b1;
    applyStimulus(8'h33);
    load_req = 1'b0;
    applyStimulus(8'h44);
    applyStimulus(8'h55);
    checkOutput("n2_w0_we",      32'(b_mem_we), 32'd1);
    checkOutput("n2_w0_addr",    32'(b_mem_address), 32'hFFFF);
    checkOutput("n2_w0_data",    b_mem_data, 32'h11223344);
    checkOutput("n2_in_ready",   32'(b_in_ready), 32'd1);
    applyStimulus(8'h66);
    checkOutput("n2_w0_one_cyc", 32'(b_mem_we), 32'd0);
    checkOutput("n2_state_data", 32'(dut_b.state), 32'(DATA));
    applyStimulus(8'h77);
    applyStimulus(8'h88);
    applyStimulus(8'h8A);
    checkOutput("n2_w1_we",      32'(b_mem_we), 32'd1);
    checkOutput("n2_w1_addr",    32'(b_mem_address), 32'h0000);
    checkOutput("n2_w1_data",    b_mem_data, 32'h55667788);
    checkOutput("n2_a_w1_addr",  32'(a_mem_address), 32'h0001);
    idleCycle();
    checkOutput("n2_cpu_rst_lo", 32'(b_cpu_reset), 32'd0);
    checkOutput("n2_load_error", 32'(b_load_error), 32'd0);

    // N=0: header and checksum only, never a write
    pulseLoadReq();
    applyStimulus(8'h00);
    checkOutput("n0_we_0", 32'(a_mem_we), 32'd0);
    applyStimulus(8'h00);
    checkOutput("n0_we_1", 32'(a_mem_we), 32'd0);
    applyStimulus(8'h00);
    checkOutput("n0_state_csum", 32'(dut_a.state), 32'(CSUM));
    checkOutput("n0_we_2", 32'(a_mem_we), 32'd0);
    idleCycle();
    checkOutput("n0_state_run",  32'(dut_a.state), 32'(RUN));
    checkOutput("n0_cpu_rst_lo", 32'(a_cpu_reset), 32'd0);
    checkOutput("n0_we_3",       32'(a_mem_we), 32'd0);

    // Bad checksum: 5D sent where 23 is due
    pulseLoadReq();
    applyStimulus(8'h00);
    applyStimulus(8'h01);
    applyStimulus(8'hDE);
    applyStimulus(8'hAD);
    applyStimulus(8'hBE);
    applyStimulus(8'hEF);
    applyStimulus(8'h5D);
    idleCycle();
    checkOutput("err_state",      32'(dut_a.state), 32'(ERROR));
    checkOutput("err_load_error", 32'(a_load_error), 32'd1);
    checkOutput("err_cpu_rst",    32'(a_cpu_reset), 32'd1);
    checkOutput("err_in_ready",   32'(a_in_ready), 32'd0);
    idleCycle();
    checkOutput("err_hold",       32'(a_load_error), 32'd1);
    pulseLoadReq();
    checkOutput("err_clr_state",  32'(dut_a.state), 32'(LEN_HI));
    checkOutput("err_clr_flag",   32'(a_load_error), 32'd0);
    checkOutput("err_clr_cpurst", 32'(a_cpu_reset), 32'd1);

    // Reset after the second data byte abandons the load
    applyStimulus(8'h00);
    applyStimulus(8'h01);
    applyStimulus(8'hDE);
    applyStimulus(8'hAD);
    idleCycle();
    checkOutput("abn_in_data", 32'(dut_a.state), 32'(DATA));
    #1;
    reset = 1'b1;
    #1;
    checkOutput("abn_state",   32'(dut_a.state), 32'(LEN_HI));
    checkOutput("abn_cpu_rst", 32'(a_cpu_reset), 32'd1);
    checkOutput("abn_we",      32'(a_mem_we), 32'd0);
    idleCycle();
    reset = 1'b0;
    idleCycle();
    checkOutput("abn_no_write", 32'(a_mem_we), 32'd0);

    // Fresh load after the abandoned one: CAFEBABE, checksum 31
    applyStimulus(8'h00);
    applyStimulus(8'h01);
    applyStimulus(8'hCA);
    applyStimulus(8'hFE);
    applyStimulus(8'hBA);
    applyStimulus(8'hBE);
    applyStimulus(8'h31);
    checkOutput("fresh_we",   32'(a_mem_we), 32'd1);
    checkOutput("fresh_addr", 32'(a_mem_address), 32'h0000);
    checkOutput("fresh_data", a_mem_data, 32'hCAFEBABE);
    idleCycle();
    checkOutput("fresh_cpu_rst", 32'(a_cpu_reset), 32'd0);
    checkOutput("fresh_error",   32'(a_load_error), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
